// File: rtl/shift_ram_pkg.sv
// shift_ram_pkg: shared sizes and FSM encoding for the shift-RAM arbiter slice.
package shift_ram_pkg;
   localparam int DATA_WIDTH = 8;
   localparam int DEPTH      = 8;
   localparam int ADDR_WIDTH = 3;
   typedef enum logic {ST_RUN = 1'b0, ST_CLR = 1'b1} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; the pointer names the client that wins a tie.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt
);
   logic prio_q, prio_d;
   always_comb begin
      gnt    = !en ? 2'b00 : (req == 2'b11) ? (prio_q ? 2'b10 : 2'b01) : req;
      prio_d = gnt[0] ? 1'b1 : gnt[1] ? 1'b0 : prio_q;
   end
   always_ff @(posedge clk) prio_q <= reset ? 1'b0 : prio_d;
endmodule

// File: rtl/shift_ram_arbiter.sv
// shift_ram_arbiter: shares a push-on-write shift RAM between two clients,
// tracks its fill level and returns read data one cycle after acceptance.
module shift_ram_arbiter
   import shift_ram_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clr,
   input  logic [1:0]              req,
   input  logic [1:0]              cmd_we,
   input  logic [2*ADDR_WIDTH-1:0] cmd_addr,
   input  logic [2*DATA_WIDTH-1:0] cmd_wdata,
   output logic [1:0]              gnt,
   output logic [1:0]              rvalid,
   output logic                    rerr,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [ADDR_WIDTH:0]     fill,
   output logic                    busy,
   output logic                    ram_en,
   output logic                    ram_we,
   output logic [ADDR_WIDTH-1:0]   ram_addr,
   output logic [DATA_WIDTH-1:0]   ram_di,
   output logic                    ram_rst,
   input  logic [DATA_WIDTH-1:0]   ram_do
);
   localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);
   state_t                state_q, state_d;
   logic [ADDR_WIDTH:0]   fill_q, fill_d;
   logic [1:0]            rvalid_q, rvalid_d;
   logic                  rerr_q, rerr_d;
   logic                  acc, sel, squash;
   logic [ADDR_WIDTH-1:0] addr;

   rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .en    (!reset && state_q == ST_RUN && !clr),
      .gnt   (gnt)
   );

   always_comb begin
      acc      = |gnt;
      sel      = gnt[1];
      addr     = sel ? cmd_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : cmd_addr[ADDR_WIDTH-1:0];
      ram_en   = acc;
      ram_we   = acc && cmd_we[sel];
      ram_addr = acc ? addr : '0;
      ram_di   = acc ? (sel ? cmd_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : cmd_wdata[DATA_WIDTH-1:0]) : '0;
      ram_rst  = reset || state_q == ST_CLR;
      busy     = state_q == ST_CLR;
      fill     = fill_q;
      // a clear or reset landing on the return cycle kills the pending read
      squash   = reset || clr;
      rvalid   = squash ? 2'b00 : rvalid_q;
      rerr     = !squash && rerr_q;
      rdata    = (|rvalid && !rerr) ? ram_do : '0;
      state_d  = (state_q == ST_RUN && clr) ? ST_CLR : ST_RUN;
      fill_d   = (state_q == ST_CLR) ? '0 : (ram_we && fill_q != FULL) ? fill_q + 1'b1 : fill_q;
      rvalid_d = (acc && !ram_we) ? gnt : 2'b00;
      rerr_d   = acc && !ram_we && {1'b0, addr} >= fill_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_RUN;
         fill_q   <= '0;
         rvalid_q <= '0;
         rerr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         fill_q   <= fill_d;
         rvalid_q <= rvalid_d;
         rerr_q   <= rerr_d;
      end
   end
endmodule

// File: tb/tb_shift_ram_arbiter.sv
// tb_shift_ram_arbiter: directed stimulus with a queue-based reference model
// checked every cycle, plus literal expectations from the test plan.
module tb_shift_ram_arbiter;
   import shift_ram_pkg::*;
   logic clk = 0, reset = 1, clr = 0;
   logic [1:0] req = 0, cmd_we = 0;
   logic [2*ADDR_WIDTH-1:0] cmd_addr = 0;
   logic [2*DATA_WIDTH-1:0] cmd_wdata = 0;
   logic [1:0] gnt, rvalid;
   logic rerr, busy, ram_en, ram_we, ram_rst;
   logic [DATA_WIDTH-1:0] rdata, ram_di, ram_do;
   logic [ADDR_WIDTH:0] fill;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   int checks = 0, errors = 0;
   bit chk_on = 0;

   always #5 clk = ~clk;

   shift_ram_arbiter dut (
      .clk(clk), .reset(reset), .clr(clr), .req(req), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .gnt(gnt), .rvalid(rvalid),
      .rerr(rerr), .rdata(rdata), .fill(fill), .busy(busy), .ram_en(ram_en),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_rst(ram_rst),
      .ram_do(ram_do)
   );

   // Shift-in RAM: a write pushes at entry 0, a read registers mem[addr].
   always @(posedge clk) begin
      if (ram_rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         ram_do <= '0;
      end else if (ram_en) begin
         if (ram_we) begin
            mem[0] <= ram_di;
            for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
         end else ram_do <= mem[ram_addr];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: contents as a queue (newest first), size is the fill level.
   int q[$];
   bit m_clr = 0, m_prio = 0, m_acc, p_err = 0;
   logic [1:0] m_eg, p_rv = 0;
   int m_k, m_a, m_d, p_data = 0;

   always @(negedge clk) begin
      m_eg = 2'b00;
      if (!reset && !m_clr && !clr)
         m_eg = (req == 2'b11) ? (m_prio ? 2'b10 : 2'b01) : req;
      m_acc = m_eg != 2'b00;
      m_k = m_eg[1] ? 1 : 0;
      m_a = int'(cmd_addr[m_k*ADDR_WIDTH +: ADDR_WIDTH]);
      m_d = int'(cmd_wdata[m_k*DATA_WIDTH +: DATA_WIDTH]);
      if (chk_on) begin
         check("m_gnt", gnt, m_eg);
         check("m_ram_en", ram_en, m_acc);
         check("m_ram_we", ram_we, m_acc && cmd_we[m_k]);
         check("m_ram_addr", ram_addr, m_acc ? m_a : 0);
         check("m_ram_di", ram_di, m_acc ? m_d : 0);
         check("m_ram_rst", ram_rst, reset || m_clr);
         check("m_busy", busy, m_clr);
         check("m_fill", fill, q.size());
         check("m_rvalid", rvalid, (reset || clr) ? 2'b00 : p_rv);
         if (!reset && !clr && p_rv != 0) begin
            check("m_rerr", rerr, p_err);
            check("m_rdata", rdata, p_data);
         end
      end
      if (reset) begin
         m_clr = 0; m_prio = 0; q.delete(); p_rv = 0;
      end else if (m_clr) begin
         m_clr = 0; q.delete(); p_rv = 0;
      end else if (clr) begin
         m_clr = 1; p_rv = 0;
      end else begin
         p_rv = 0;
         if (m_acc) begin
            m_prio = (m_k == 0);
            if (cmd_we[m_k]) begin
               q.push_front(m_d);
               if (q.size() > DEPTH) void'(q.pop_back());
            end else begin
               p_rv = m_eg;
               p_err = m_a >= q.size();
               p_data = p_err ? 0 : q[m_a];
            end
         end
      end
   end

   // Present one command and hold it until granted; returns just after the
   // accepting edge, i.e. inside the read-return cycle.
   task automatic issue(input int k, input bit we, input int addr, input int data);
      int n = 0;
      @(posedge clk); #1;
      req[k] = 1'b1;
      cmd_we[k] = we;
      cmd_addr[k*ADDR_WIDTH +: ADDR_WIDTH] = addr[ADDR_WIDTH-1:0];
      cmd_wdata[k*DATA_WIDTH +: DATA_WIDTH] = data[DATA_WIDTH-1:0];
      @(negedge clk);
      while (!gnt[k] && n < 20) begin @(negedge clk); n++; end
      check("grant_timeout", gnt[k], 1'b1);
      @(posedge clk); #1;
      req[k] = 1'b0;
   endtask

   initial begin
      @(posedge clk); #1;
      chk_on = 1;
      req = 2'b11;
      @(negedge clk);
      check("rst_gnt", gnt, 2'b00);
      check("rst_ram_rst", ram_rst, 1'b1);
      check("rst_fill", fill, 0);
      @(posedge clk); #1;
      req = 2'b00;
      reset = 0;
      // basic write/write/read
      issue(0, 1, 0, 8'hA1);
      issue(0, 1, 0, 8'hB2);
      issue(0, 0, 1, 0);
      check("rd1_rvalid", rvalid, 2'b01);
      check("rd1_rdata", rdata, 8'hA1);
      check("rd1_rerr", rerr, 1'b0);
      check("rd1_fill", fill, 2);
      issue(1, 0, 0, 0);
      check("rd2_rvalid", rvalid, 2'b10);
      check("rd2_rdata", rdata, 8'hB2);
      // both clients read every cycle: client0 addr0, client1 addr1
      @(posedge clk); #1;
      cmd_we = 2'b00;
      cmd_addr = {3'd1, 3'd0};
      req = 2'b11;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("alt_gnt", gnt, (i % 2) ? 2'b10 : 2'b01);
         if (i > 0) begin
            check("alt_rvalid", rvalid, (i % 2) ? 2'b01 : 2'b10);
            check("alt_rdata", rdata, (i % 2) ? 8'hB2 : 8'hA1);
         end
         @(posedge clk); #1;
      end
      req = 2'b00;
      @(negedge clk);
      check("alt_last_rvalid", rvalid, 2'b10);
      // saturation
      for (int i = 1; i <= 10; i++) issue(0, 1, 0, i);
      check("sat_fill", fill, 8);
      issue(0, 0, 7, 0);
      check("sat_rd7", rdata, 8'h03);
      issue(1, 0, 0, 0);
      check("sat_rd0", rdata, 8'h0A);
      check("sat_rd0_rv", rvalid, 2'b10);
      // clear, then an out-of-range read with fill=2
      @(posedge clk); #1 clr = 1;
      @(posedge clk); #1 clr = 0;
      @(negedge clk);
      check("clr_busy", busy, 1'b1);
      check("clr_ram_rst", ram_rst, 1'b1);
      issue(0, 1, 0, 8'h11);
      issue(0, 1, 0, 8'h22);
      issue(0, 0, 5, 0);
      check("oor_rvalid", rvalid, 2'b01);
      check("oor_rerr", rerr, 1'b1);
      check("oor_rdata", rdata, 0);
      check("oor_fill", fill, 2);
      // read squashed by a clr pulse on its return cycle
      issue(0, 0, 0, 0);
      clr = 1;
      req[1] = 1'b1;
      cmd_we[1] = 1'b0;
      cmd_addr[5:3] = 3'd0;
      @(negedge clk);
      check("sq_rvalid", rvalid, 2'b00);
      check("sq_gnt", gnt, 2'b00);
      check("sq_ram_rst", ram_rst, 1'b0);
      @(posedge clk); #1 clr = 0;
      @(negedge clk);
      check("sq_clr_gnt", gnt, 2'b00);
      check("sq_clr_ram_rst", ram_rst, 1'b1);
      check("sq_clr_busy", busy, 1'b1);
      @(negedge clk);
      check("sq_post_gnt", gnt, 2'b10);
      check("sq_post_fill", fill, 0);
      @(posedge clk); #1 req = 2'b00;
      @(negedge clk);
      check("sq_post_rvalid", rvalid, 2'b10);
      check("sq_post_rerr", rerr, 1'b1);
      // reset mid-stream with both requests held
      @(posedge clk); #1;
      cmd_we = 2'b00;
      req = 2'b11;
      repeat (3) @(posedge clk);
      #1 reset = 1;
      @(negedge clk);
      check("mid_rst_gnt", gnt, 2'b00);
      check("mid_rst_ram_rst", ram_rst, 1'b1);
      @(posedge clk); #1 reset = 0;
      @(negedge clk);
      check("mid_rst_first_gnt", gnt, 2'b01);
      @(posedge clk); #1 req = 2'b00;
      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/shift_ram_arbiter.md
Name: shift_ram_arbiter

Overview:
- Two-client arbiter and sequencer in front of the 8-entry shift-in RAM (push-on-write, random-address read).
- Shares the RAM between two requesters using round-robin arbitration with a req/gnt handshake.
- Drives the RAM control signals en/we/addr/di and its reset, and returns read data with fixed latency.
- Tracks the RAM fill level and flags reads of never-written entries.

Parameters:
- DATA_WIDTH, 8, width of the data word.
- DEPTH, 8, number of RAM entries; must equal the RAM array size.
- ADDR_WIDTH, 3, RAM address width; must satisfy 2**ADDR_WIDTH >= DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- clr  in  1  one-cycle pulse requesting a RAM clear.
- req  in  2  per-client request; bit k belongs to client k.
- cmd_we  in  2  per-client command type; 1 = write (push), 0 = read.
- cmd_addr  in  2*ADDR_WIDTH  per-client read address; client k uses slice k.
- cmd_wdata  in  2*DATA_WIDTH  per-client write data; client k uses slice k.
- gnt  out  2  one-hot grant, combinational.
- rvalid  out  2  read-data valid, one bit per client.
- rerr  out  1  the returned read targeted an entry not yet written.
- rdata  out  DATA_WIDTH  read data, shared by both clients.
- fill  out  ADDR_WIDTH+1  number of valid entries, 0..DEPTH.
- busy  out  1  high while the block is clearing.
- ram_en, ram_we  out  1 each  RAM enable and write enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_di  out  DATA_WIDTH  RAM write data.
- ram_rst  out  1  RAM reset.
- ram_do  in  DATA_WIDTH  RAM registered output.

Behaviour:
- Reset values (reset high at a clk edge):
  - state=RUN, prio pointer=0, fill=0.
  - rvalid=0, rerr=0, busy=0.
  - ram_rst=1 combinationally for as long as reset is high.
  - gnt=0 while reset is high.
- FSM has two states, RUN and CLR:
  - RUN with clr=1: go to CLR. No grant is issued in that cycle.
  - CLR lasts exactly one cycle: ram_rst=1, busy=1, gnt=0, fill<=0. Then return to RUN.
  - clr is ignored while in CLR.
- Arbitration (RUN, clr=0):
  - Only one requester: grant it.
  - Both requesting: grant the prio-pointer client.
  - After a grant to client k, prio<=~k. Prio is unchanged when nothing is granted.
- Handshake:
  - A transaction is accepted in the cycle where req[k]&&gnt[k].
  - The client holds req and its command stable until it is granted.
  - The client may drop req before the grant with no side effect.
- On acceptance, the RAM is driven combinationally in the same cycle:
  - ram_en=1, ram_we=cmd_we[k], ram_addr=cmd_addr slice k, ram_di=cmd_wdata slice k.
  - All ram_* signals are 0 when nothing is accepted.
- Write:
  - The RAM shifts at that edge.
  - fill<=fill+1, saturating at DEPTH. At saturation the oldest entry is silently lost.
  - No rvalid is produced for a write.
- Read:
  - Latency 1. In the cycle after acceptance, rvalid[k]=1 for one cycle and rdata=ram_do.
  - rerr=1 with that rvalid if addr >= fill sampled at acceptance; rdata is then 0.
- Back-to-back operation: one accepted transaction per cycle at most. A read and a write in consecutive cycles are legal.
- Read directly after a write: in the cycle after a write, fill already includes the new entry, so a read of addr 0 returns the just-written data.
- Reset or clr mid-read: a pending rvalid is squashed (forced 0) if CLR or reset occurs in the cycle it would assert.
- Addresses >= DEPTH (possible only if DEPTH<2**ADDR_WIDTH) are treated as rerr.

Decomposition:
- Shared package shift_ram_pkg holds:
  - Localparams DATA_WIDTH, DEPTH, ADDR_WIDTH.
  - The state encoding ST_RUN=1'b0, ST_CLR=1'b1.
- One sub-module, rr_arb2: two-way round-robin grant logic with the priority pointer (req, accept, pointer -> gnt).
- The FSM, fill counter and read-return pipeline stay in the top level.

Test Plan:
- After reset, client0 writes 0xA1, then 0xB2, then reads addr1 -> rvalid[0] one cycle after its gnt, rdata=0xA1, rerr=0, fill=2.
- Both clients request reads every cycle for 6 cycles -> gnt alternates 01,10,01,... starting with client0; each rvalid lands on the matching client.
- Ten writes 0x01..0x0A -> fill saturates at 8; a read of addr7 returns 0x03 and a read of addr0 returns 0x0A.
- With fill=2, a read of addr5 -> rvalid=1, rerr=1, rdata=0.
- A read is accepted, then clr pulses in the next cycle -> rvalid is squashed, ram_rst=1 for one cycle, gnt=0 in the clr and CLR cycles, fill=0; a subsequent read of addr0 gives rerr=1.
- reset is asserted mid-stream with req held -> gnt=0 and ram_rst=1 during reset; the first grant after release goes to client0.
